// File: rtl/ctrl_pkg.sv
// Opcode match constants, register constants and stage record for the Thumb-subset pipeline tracker.
package ctrl_pkg;

  localparam int CTRL_IR_W  = 16;
  localparam int CTRL_REG_AW = 4;

  // Patterns apply to ir[15:7]; the mask marks the opcode bits that must match.
  localparam logic [8:0] ADD_IMM      = 9'b0001110_00;
  localparam logic [8:0] ADD_IMM_MASK = 9'b1111111_00;
  localparam logic [8:0] SUB_SP       = 9'b101100001;
  localparam logic [8:0] SUB_SP_MASK  = 9'b111111111;
  localparam logic [8:0] MOV_IMM      = 9'b00100_0000;
  localparam logic [8:0] MOV_IMM_MASK = 9'b11111_0000;
  localparam logic [8:0] MOV_REG      = 9'b01000110_0;
  localparam logic [8:0] MOV_REG_MASK = 9'b11111111_0;
  localparam logic [8:0] LDR_IMM      = 9'b01101_0000;
  localparam logic [8:0] LDR_IMM_MASK = 9'b11111_0000;

  localparam logic [CTRL_REG_AW-1:0] SP_ADDR = 4'd13;

  typedef struct packed {
    logic [CTRL_IR_W-1:0]   ir;
    logic [CTRL_REG_AW-1:0] rd_addr;
    logic                   rd_en;
  } stage_t;

  function automatic logic op_match(input logic [8:0] op, input logic [8:0] pat,
                                    input logic [8:0] mask);
    return (op & mask) == pat;
  endfunction

endpackage

// File: rtl/ctrl_rd_decode.sv
// Combinational destination-register decode for an instruction entering the tracked pipeline.
module ctrl_rd_decode
  import ctrl_pkg::*;
#(
  parameter int IR_W   = 16,
  parameter int REG_AW = 4
) (
  input  logic [IR_W-1:0]   ir,
  input  logic              valid,
  input  logic              flush,
  output logic [REG_AW-1:0] rd_addr,
  output logic              rd_en
);

  logic [8:0] op;
  logic [3:0] rd;
  logic       match;
  logic       unused_ir_bits;

  assign op             = ir[15:7];
  assign unused_ir_bits = ^ir;

  always_comb begin
    rd    = '0;
    match = 1'b0;
    if (op_match(op, ADD_IMM, ADD_IMM_MASK)) begin
      rd    = {1'b0, ir[2:0]};
      match = 1'b1;
    end else if (op_match(op, SUB_SP, SUB_SP_MASK)) begin
      rd    = SP_ADDR;
      match = 1'b1;
    end else if (op_match(op, MOV_IMM, MOV_IMM_MASK)) begin
      rd    = {1'b0, ir[10:8]};
      match = 1'b1;
    end else if (op_match(op, MOV_REG, MOV_REG_MASK)) begin
      // ir[7] selects the high register bank
      rd    = {ir[7], ir[2:0]};
      match = 1'b1;
    end else if (op_match(op, LDR_IMM, LDR_IMM_MASK)) begin
      rd    = {1'b0, ir[2:0]};
      match = 1'b1;
    end
  end

  assign rd_addr = REG_AW'(rd);
  assign rd_en   = match & valid & ~flush;

endmodule

// File: rtl/ctrl_pipe_track.sv
// Pipeline control tracker: IR/rd per stage, writeback strobe, RAW hazard and forward select.
// Optional performance counters enabled with `define CTRL_PIPE_PERF_EN.
module ctrl_pipe_track
  import ctrl_pkg::*;
#(
  parameter int IR_W   = 16,
  parameter int DEPTH  = 3,
  parameter int REG_AW = 4,
  parameter int N_SRC  = 2
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    i_stall,
  input  logic                    i_flush,
  input  logic [IR_W-1:0]         i_ir,
  input  logic                    i_valid,
  input  logic [N_SRC*REG_AW-1:0] i_src_addr,
  input  logic [N_SRC-1:0]        i_src_en,
  output logic [IR_W-1:0]         o_ir_wb_r,
  output logic [DEPTH*REG_AW-1:0] o_rd_addr_r,
  output logic [DEPTH-1:0]        o_rd_en_r,
  output logic                    o_wb_en_r,
  output logic [N_SRC-1:0]        o_hazard,
  output logic [N_SRC*3-1:0]      o_fwd_sel
`ifdef CTRL_PIPE_PERF_EN
  ,
  output logic [31:0]             o_stall_cnt_r,
  output logic [31:0]             o_hazard_cnt_r
`endif
);

  logic [IR_W-1:0]   ir_reg      [DEPTH];
  logic [REG_AW-1:0] rd_addr_reg [DEPTH];
  logic              rd_en_reg   [DEPTH];

  logic [REG_AW-1:0] dec_rd_addr;
  logic              dec_rd_en;

  ctrl_rd_decode #(
    .IR_W  (IR_W),
    .REG_AW(REG_AW)
  ) u_rd_decode (
    .ir     (i_ir),
    .valid  (i_valid),
    .flush  (i_flush),
    .rd_addr(dec_rd_addr),
    .rd_en  (dec_rd_en)
  );

  // Flush overrides stall for stage 0 only; older stages follow the stall alone.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int n = 0; n < DEPTH; n++) begin
        ir_reg[n]      <= '0;
        rd_addr_reg[n] <= '0;
        rd_en_reg[n]   <= 1'b0;
      end
    end else begin
      if (i_flush) begin
        ir_reg[0]      <= '0;
        rd_addr_reg[0] <= '0;
        rd_en_reg[0]   <= 1'b0;
      end else if (!i_stall) begin
        ir_reg[0]      <= i_ir;
        rd_addr_reg[0] <= dec_rd_addr;
        rd_en_reg[0]   <= dec_rd_en;
      end
      if (!i_stall) begin
        for (int n = 1; n < DEPTH; n++) begin
          ir_reg[n]      <= ir_reg[n-1];
          rd_addr_reg[n] <= rd_addr_reg[n-1];
          rd_en_reg[n]   <= rd_en_reg[n-1];
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      o_wb_en_r <= 1'b0;
    end else begin
      o_wb_en_r <= ~i_stall & rd_en_reg[DEPTH-2];
    end
  end

  assign o_ir_wb_r = ir_reg[DEPTH-1];

  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_stage_out
      assign o_rd_addr_r[gi*REG_AW +: REG_AW] = rd_addr_reg[gi];
      assign o_rd_en_r[gi]                    = rd_en_reg[gi];
    end
  endgenerate

  generate
    for (genvar gi = 0; gi < N_SRC; gi++) begin : g_hazard
      logic [REG_AW-1:0] src;
      logic              hit;
      logic [2:0]        sel;

      assign src = i_src_addr[gi*REG_AW +: REG_AW];

      // Scan oldest to youngest so the youngest matching producer is the last to win.
      always_comb begin
        hit = 1'b0;
        sel = '0;
        for (int n = DEPTH - 1; n >= 0; n--) begin
          if (i_src_en[gi] && rd_en_reg[n] && (rd_addr_reg[n] == src)) begin
            hit = 1'b1;
            sel = 3'(n);
          end
        end
      end

      assign o_hazard[gi]        = hit;
      assign o_fwd_sel[gi*3 +: 3] = sel;
    end
  endgenerate

`ifdef CTRL_PIPE_PERF_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      o_stall_cnt_r  <= '0;
      o_hazard_cnt_r <= '0;
    end else begin
      if (i_stall && (o_stall_cnt_r != 32'hFFFF_FFFF)) begin
        o_stall_cnt_r <= o_stall_cnt_r + 32'd1;
      end
      if ((|o_hazard) && (o_hazard_cnt_r != 32'hFFFF_FFFF)) begin
        o_hazard_cnt_r <= o_hazard_cnt_r + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_ctrl_pipe_track.sv
// Self-checking bench for ctrl_pipe_track: decode table, hand-written corner sequences, random vs model.
module tb_ctrl_pipe_track;

  localparam int IR_W   = 16;
  localparam int DEPTH  = 3;
  localparam int REG_AW = 4;
  localparam int N_SRC  = 2;

  logic                    clk;
  logic                    rst_n;
  logic                    i_stall;
  logic                    i_flush;
  logic [IR_W-1:0]         i_ir;
  logic                    i_valid;
  logic [N_SRC*REG_AW-1:0] i_src_addr;
  logic [N_SRC-1:0]        i_src_en;
  logic [IR_W-1:0]         o_ir_wb_r;
  logic [DEPTH*REG_AW-1:0] o_rd_addr_r;
  logic [DEPTH-1:0]        o_rd_en_r;
  logic                    o_wb_en_r;
  logic [N_SRC-1:0]        o_hazard;
  logic [N_SRC*3-1:0]      o_fwd_sel;
`ifdef CTRL_PIPE_PERF_EN
  logic [31:0]             o_stall_cnt_r;
  logic [31:0]             o_hazard_cnt_r;
`endif

  ctrl_pipe_track #(
    .IR_W(IR_W), .DEPTH(DEPTH), .REG_AW(REG_AW), .N_SRC(N_SRC)
  ) dut (
    .clk(clk), .rst_n(rst_n), .i_stall(i_stall), .i_flush(i_flush),
    .i_ir(i_ir), .i_valid(i_valid), .i_src_addr(i_src_addr), .i_src_en(i_src_en),
    .o_ir_wb_r(o_ir_wb_r), .o_rd_addr_r(o_rd_addr_r), .o_rd_en_r(o_rd_en_r),
    .o_wb_en_r(o_wb_en_r), .o_hazard(o_hazard), .o_fwd_sel(o_fwd_sel)
`ifdef CTRL_PIPE_PERF_EN
    , .o_stall_cnt_r(o_stall_cnt_r), .o_hazard_cnt_r(o_hazard_cnt_r)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference model: one record per stage, plus the strobe and counters.
  logic [15:0] m_ir [DEPTH];
  logic [3:0]  m_rd [DEPTH];
  logic        m_en [DEPTH];
  logic        m_wb;
  logic [31:0] m_stall_cnt;
  logic [31:0] m_haz_cnt;

  // Thumb-subset destination decode, straight from the instruction formats.
  task automatic ref_decode(input logic [15:0] ir, output logic hit, output logic [3:0] rd);
    hit = 1'b1;
    rd  = 4'd0;
    casez (ir[15:7])
      9'b0001110??: rd = {1'b0, ir[2:0]};
      9'b101100001: rd = 4'd13;
      9'b00100????: rd = {1'b0, ir[10:8]};
      9'b01000110?: rd = {ir[7], ir[2:0]};
      9'b01101????: rd = {1'b0, ir[2:0]};
      default: hit = 1'b0;
    endcase
  endtask

  task automatic model_reset();
    for (int n = 0; n < DEPTH; n++) begin
      m_ir[n] = '0; m_rd[n] = '0; m_en[n] = 1'b0;
    end
    m_wb = 1'b0;
    m_stall_cnt = '0;
    m_haz_cnt = '0;
  endtask

  task automatic ref_hazard(output logic [N_SRC-1:0] hz, output logic [N_SRC*3-1:0] fs);
    hz = '0;
    fs = '0;
    for (int k = 0; k < N_SRC; k++) begin
      bit found;
      found = 0;
      for (int n = 0; n < DEPTH; n++) begin
        if (!found && i_src_en[k] && m_en[n] && m_rd[n] == i_src_addr[k*REG_AW +: REG_AW]) begin
          found = 1;
          hz[k] = 1'b1;
          fs[k*3 +: 3] = 3'(n);
        end
      end
    end
  endtask

  task automatic model_step();
    logic hit;
    logic [3:0] rd;
    logic [N_SRC-1:0] hz;
    logic [N_SRC*3-1:0] fs;
    ref_hazard(hz, fs);
    if (i_stall && m_stall_cnt != 32'hFFFF_FFFF) m_stall_cnt++;
    if ((|hz) && m_haz_cnt != 32'hFFFF_FFFF) m_haz_cnt++;
    ref_decode(i_ir, hit, rd);
    if (!i_stall) begin
      m_wb = m_en[DEPTH-2];
      for (int n = DEPTH - 1; n >= 1; n--) begin
        m_ir[n] = m_ir[n-1]; m_rd[n] = m_rd[n-1]; m_en[n] = m_en[n-1];
      end
    end else begin
      m_wb = 1'b0;
    end
    if (i_flush) begin
      m_ir[0] = '0; m_rd[0] = '0; m_en[0] = 1'b0;
    end else if (!i_stall) begin
      m_ir[0] = i_ir; m_rd[0] = rd; m_en[0] = hit & i_valid;
    end
  endtask

  task automatic check_hazard();
    logic [N_SRC-1:0] hz;
    logic [N_SRC*3-1:0] fs;
    ref_hazard(hz, fs);
    chk("hazard", o_hazard, hz);
    chk("fwd_sel", o_fwd_sel, fs);
  endtask

  task automatic check_regs();
    logic [DEPTH*REG_AW-1:0] ea;
    logic [DEPTH-1:0] ee;
    for (int n = 0; n < DEPTH; n++) begin
      ea[n*REG_AW +: REG_AW] = m_rd[n];
      ee[n] = m_en[n];
    end
    chk("ir_wb", o_ir_wb_r, m_ir[DEPTH-1]);
    chk("rd_addr", o_rd_addr_r, ea);
    chk("rd_en", o_rd_en_r, ee);
    chk("wb_en", o_wb_en_r, m_wb);
`ifdef CTRL_PIPE_PERF_EN
    chk("stall_cnt", o_stall_cnt_r, m_stall_cnt);
    chk("hazard_cnt", o_hazard_cnt_r, m_haz_cnt);
`endif
  endtask

  // Inputs change 1 time unit after the rising edge; hazards are checked before the next edge.
  task automatic drive(input logic stall, input logic flush, input logic [15:0] ir,
                       input logic valid, input logic [7:0] src, input logic [1:0] sen);
    i_stall = stall; i_flush = flush; i_ir = ir; i_valid = valid;
    i_src_addr = src; i_src_en = sen;
    #1;
    check_hazard();
  endtask

  task automatic step();
    @(posedge clk);
    model_step();
    #1;
    check_regs();
  endtask

  task automatic cycle(input logic stall, input logic flush, input logic [15:0] ir, input logic valid);
    drive(stall, flush, ir, valid, 8'h00, 2'b00);
    step();
  endtask

  typedef struct {
    logic [15:0] ir;
    logic        en;
    logic [3:0]  rd;
  } dvec_t;

  dvec_t dt [6];

  initial begin
    #200000;
    $display("FAIL timeout: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int pulses;
    dt[0] = '{16'h1C51, 1'b1, 4'd1};
    dt[1] = '{16'hB081, 1'b1, 4'd13};
    dt[2] = '{16'h2305, 1'b1, 4'd3};
    dt[3] = '{16'h4687, 1'b1, 4'd15};
    dt[4] = '{16'h6808, 1'b1, 4'd0};
    dt[5] = '{16'hE000, 1'b0, 4'd0};

    rst_n = 1'b0; i_stall = 0; i_flush = 0; i_ir = 0; i_valid = 0;
    i_src_addr = 0; i_src_en = 0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("reset_rd_en", o_rd_en_r, 3'b000);
    chk("reset_wb", o_wb_en_r, 1'b0);
    chk("reset_ir_wb", o_ir_wb_r, 16'h0000);
    rst_n = 1'b1;

    // Single ADD through the pipe
    cycle(0, 0, 16'h1C51, 1);
    chk("add_en0", o_rd_en_r[0], 1'b1);
    chk("add_rd0", o_rd_addr_r[3:0], 4'd1);
    cycle(0, 0, 16'h0000, 0);
    cycle(0, 0, 16'h0000, 0);
    chk("add_ir_wb", o_ir_wb_r, 16'h1C51);
    chk("add_wb_on", o_wb_en_r, 1'b1);
    cycle(0, 0, 16'h0000, 0);
    chk("add_wb_off", o_wb_en_r, 1'b0);

    // Decode table
    for (int i = 0; i < 6; i++) begin
      cycle(0, 0, dt[i].ir, 1);
      chk("dec_en", o_rd_en_r[0], dt[i].en);
      chk("dec_rd", o_rd_addr_r[3:0], dt[i].rd);
    end

    // Stall with the instruction in stage 1, then in stage 2
    repeat (3) cycle(0, 0, 16'h0000, 0);
    cycle(0, 0, 16'h2305, 1);
    cycle(0, 0, 16'h0000, 0);
    for (int i = 0; i < 2; i++) begin
      cycle(1, 0, 16'h1C51, 1);
      chk("stall_wb", o_wb_en_r, 1'b0);
      chk("stall_rd1", o_rd_addr_r[7:4], 4'd3);
      chk("stall_en1", o_rd_en_r[1], 1'b1);
    end
    pulses = 0;
    cycle(0, 0, 16'h0000, 0);
    chk("stall_ir_wb", o_ir_wb_r, 16'h2305);
    pulses += int'(o_wb_en_r);
    for (int i = 0; i < 2; i++) begin
      cycle(1, 0, 16'h0000, 0);
      chk("stall2_ir_wb", o_ir_wb_r, 16'h2305);
      pulses += int'(o_wb_en_r);
    end
    for (int i = 0; i < 3; i++) begin
      cycle(0, 0, 16'h0000, 0);
      pulses += int'(o_wb_en_r);
    end
    chk("wb_pulses", 64'(pulses), 64'd1);

    // Flush alone, then flush with stall
    cycle(0, 0, 16'h2305, 1);
    cycle(0, 1, 16'h2305, 1);
    chk("flush_en0", o_rd_en_r[0], 1'b0);
    chk("flush_rd0", o_rd_addr_r[3:0], 4'd0);
    chk("flush_en1", o_rd_en_r[1], 1'b1);
    cycle(0, 0, 16'h2305, 1);
    cycle(1, 1, 16'h2305, 1);
    chk("fstall_en", o_rd_en_r, 3'b100);
    chk("fstall_ir_wb", o_ir_wb_r, 16'h2305);
    cycle(0, 0, 16'h0000, 0);
    chk("flushed_ir_wb", o_ir_wb_r, 16'h0000);

    // Hazard: stages 0 and 2 both write r3; youngest wins, then clear stage 0
    repeat (3) cycle(0, 0, 16'h0000, 0);
    cycle(0, 0, 16'h2305, 1);
    cycle(0, 0, 16'h0000, 0);
    cycle(0, 0, 16'h2305, 1);
    drive(1, 1, 16'h0000, 0, 8'h03, 2'b01);
    chk("haz_both", o_hazard, 2'b01);
    chk("fwd_young", o_fwd_sel[2:0], 3'd0);
    step();
    chk("haz_old", o_hazard, 2'b01);
    chk("fwd_old", o_fwd_sel, 6'd2);
    drive(1, 0, 16'h0000, 0, 8'h33, 2'b10);
    chk("haz_src1", o_hazard, 2'b10);
    chk("fwd_src1", o_fwd_sel, {3'd2, 3'd0});
    step();

    // Randomised traffic against the model
    for (int i = 0; i < 400; i++) begin
      logic [15:0] ir;
      case ($urandom_range(0, 5))
        0: ir = {7'b0001110, 9'($urandom)};
        1: ir = {9'b101100001, 7'($urandom)};
        2: ir = {5'b00100, 11'($urandom)};
        3: ir = {8'b01000110, 8'($urandom)};
        4: ir = {5'b01101, 11'($urandom)};
        default: ir = 16'($urandom);
      endcase
      drive($urandom_range(0, 3) == 0, $urandom_range(0, 6) == 0, ir,
            $urandom_range(0, 7) != 0, 8'($urandom), 2'($urandom));
      step();
    end

    // Asynchronous reset with three valid instructions in flight
    cycle(0, 0, 16'h1C51, 1);
    cycle(0, 0, 16'h2305, 1);
    cycle(0, 0, 16'h4687, 1);
    chk("pre_rst_en", o_rd_en_r, 3'b111);
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst_rd_en", o_rd_en_r, 3'b000);
    chk("rst_wb", o_wb_en_r, 1'b0);
    chk("rst_ir_wb", o_ir_wb_r, 16'h0000);
`ifdef CTRL_PIPE_PERF_EN
    chk("rst_stall_cnt", o_stall_cnt_r, 32'd0);
    chk("rst_haz_cnt", o_hazard_cnt_r, 32'd0);
`endif
    model_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    cycle(0, 0, 16'h0000, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
